// File: rtl/mem_bus_responder.sv
// mem_bus_responder: memory-side responder for the 9-bit processor bus.
// Owns a program/data RAM, an LED register and four hex-display registers.
// Reads are returned after a fixed RD_LAT-cycle latency. Writes complete in
// the strobe cycle.
module mem_bus_responder #(
  parameter int DATA_W    = 9,
  parameter int ADDR_W    = 9,
  parameter int RAM_DEPTH = 128,
  parameter int RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] dout_i,
  input  logic              req_i,
  input  logic              w_i,
  output logic [DATA_W-1:0] din_o,
  output logic              din_valid_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [DATA_W-1:0] leds_o,
  output logic [6:0]        hex0_o,
  output logic [6:0]        hex1_o,
  output logic [6:0]        hex2_o,
  output logic [6:0]        hex3_o
);

  localparam int RAM_AW = $clog2(RAM_DEPTH);
  localparam int CNT_W  = 3;
  localparam logic [ADDR_W-1:0] LED_ADDR = ADDR_W'(32'h100);
  localparam logic [ADDR_W-1:0] HEX_BASE = ADDR_W'(32'h180);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(RD_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] ram [RAM_DEPTH];
  logic [6:0]        hex_q [4];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_word;
  logic              ram_hit, led_hit, hex_hit, mapped;

  assign ram_hit = (addr_i < ADDR_W'(RAM_DEPTH));
  assign led_hit = (addr_i == LED_ADDR);
  assign hex_hit = (addr_i[ADDR_W-1:2] == HEX_BASE[ADDR_W-1:2]);
  assign mapped  = ram_hit | led_hit | hex_hit;

  // Read mux: the word a request in this cycle would sample (old value on a
  // same-cycle write, since all targets update only at the clock edge).
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    rd_word = '0;
    if (ram_hit)      rd_word = ram[addr_i[RAM_AW-1:0]];
    else if (led_hit) rd_word = leds_o;
    else if (hex_hit) rd_word = DATA_W'(hex_q[addr_i[1:0]]);
  end

  // RAM write port.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset so it maps onto block memory; its
    // contents are undefined until written.
    if (w_i && ram_hit) ram[addr_i[RAM_AW-1:0]] <= dout_i;
  end

  // LED/hex registers and the sticky unmapped-access flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // register samples pre-edge values, independent of block ordering.
      leds_o <= '0;
      err_o  <= 1'b0;
      for (int i = 0; i < 4; i++) hex_q[i] <= '0;
    end else begin
      if (w_i && led_hit) leds_o <= dout_i;
      if (w_i && hex_hit) hex_q[addr_i[1:0]] <= dout_i[6:0];
      if ((req_i || w_i) && !mapped) err_o <= 1'b1;
    end
  end

  assign hex0_o = hex_q[0];
  assign hex1_o = hex_q[1];
  assign hex2_o = hex_q[2];
  assign hex3_o = hex_q[3];

  // Read FSM next state: any request (re)starts the latency count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (req_i) begin
          cnt_d   = CNT_LOAD;
          state_d = (RD_LAT == 1) ? S_DONE : S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (req_i) begin
          cnt_d   = CNT_LOAD;
          state_d = (RD_LAT == 1) ? S_DONE : S_WAIT;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read FSM state, data pipeline and returned word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rd_data_q <= '0;
      din_o     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (req_i) rd_data_q <= rd_word;
      // With RD_LAT==1 the request edge is also the DONE-entry edge, so the
      // word bypasses the sample register.
      if (state_d == S_DONE) din_o <= req_i ? rd_word : rd_data_q;
    end
  end

  assign din_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);

endmodule
